imm_gen_pipe: RTL

- Parametrised, pipelined immediate generator for the decode stage.
- Supports I/S/B/U/J formats at configurable XLEN, sign-extended to full width.
- Also produces a PC-relative sum (pc + imm) for branch, JAL and AUIPC targets.
- Sits between instruction fetch/decode and execute; valid/ready handshake on both sides, 2-entry skid buffer, pipeline flush.

---
 rtl/imm_pkg.sv | 25 ++
 rtl/imm_gen_pipe_if.sv | 28 ++
 rtl/imm_extract.sv | 46 ++++
 rtl/imm_gen_pipe.sv | 115 +++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared constants for the immediate generator: format select bits,
// FSM state encoding and the XLEN legality check.
package imm_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned FMT_W  = 5;

    localparam int unsigned FMT_I = 0;
    localparam int unsigned FMT_S = 1;
    localparam int unsigned FMT_B = 2;
    localparam int unsigned FMT_U = 3;
    localparam int unsigned FMT_J = 4;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam int unsigned XLEN_MIN = 32;
    localparam int unsigned XLEN_MAX = 64;

    function automatic bit xlen_legal(input int unsigned xlen);
        return (xlen == XLEN_MIN) || (xlen == XLEN_MAX);
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Decode-side and execute-side handshake bundle of the immediate generator.
interface imm_gen_pipe_if
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] instruction;
    logic [XLEN-1:0]   pc;
    logic              illegal;
    logic [FMT_W-1:0]  fmt;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc_rel;
    logic              imm_err;

    modport master (
        output in_valid, instruction, pc, illegal, fmt, out_ready,
        input  in_ready, out_valid, imm, pc_rel, imm_err
    );

    modport slave (
        input  in_valid, instruction, pc, illegal, fmt, out_ready,
        output in_ready, out_valid, imm, pc_rel, imm_err
    );
endinterface

// File: rtl/imm_extract.sv
// Combinational I/S/B/U/J immediate extraction with sign extension and
// the PC-relative target sum.
module imm_extract
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [INST_W-1:0] instruction,
    input  logic [XLEN-1:0]   pc,
    input  logic              illegal,
    input  logic [FMT_W-1:0]  fmt,
    output logic [XLEN-1:0]   imm,
    output logic [XLEN-1:0]   pc_rel,
    output logic              imm_err
);
    logic [31:0]     i32, s32, b32, u32, j32;
    logic [XLEN-1:0] sel;
    logic            bad;
    logic            unused_opcode;

    function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    assign i32 = {{20{instruction[31]}}, instruction[31:20]};
    assign s32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign b32 = {{20{instruction[31]}}, instruction[7], instruction[30:25],
                  instruction[11:8], 1'b0};
    assign u32 = {instruction[31:12], 12'b0};
    assign j32 = {{12{instruction[31]}}, instruction[19:12], instruction[20],
                  instruction[30:21], 1'b0};

    // fmt is one-hot whenever the result is used, so an AND-OR mux suffices
    assign sel = ({XLEN{fmt[FMT_I]}} & sext(i32))
               | ({XLEN{fmt[FMT_S]}} & sext(s32))
               | ({XLEN{fmt[FMT_B]}} & sext(b32))
               | ({XLEN{fmt[FMT_U]}} & sext(u32))
               | ({XLEN{fmt[FMT_J]}} & sext(j32));

    assign bad     = illegal || !$onehot(fmt);
    assign imm     = bad ? '0 : sel;
    assign pc_rel  = pc + imm;
    assign imm_err = bad;

    assign unused_opcode = ^instruction[6:0];
endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: extraction stage feeding an output
// register plus one skid entry, or a pure pass-through when REG_OUT=0.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter bit          REG_OUT = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);
    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc_rel;
        logic            err;
    } beat_t;

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0] x_imm;
    logic [XLEN-1:0] x_pc_rel;
    logic            x_err;
    beat_t           cur;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instruction (bus.instruction),
        .pc          (bus.pc),
        .illegal     (bus.illegal),
        .fmt         (bus.fmt),
        .imm         (x_imm),
        .pc_rel      (x_pc_rel),
        .imm_err     (x_err)
    );

    assign cur = '{imm: x_imm, pc_rel: x_pc_rel, err: x_err};

    if (REG_OUT) begin : g_reg
        logic [1:0] state, state_n;
        beat_t      out_q, skid_q;
        logic       in_acc, out_acc;
        logic       load_out, load_skid, skid_to_out;

        assign in_acc  = bus.in_valid && (state != ST_TWO);
        assign out_acc = (state != ST_EMPTY) && bus.out_ready;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) state <= ST_EMPTY;
            else        state <= state_n;
        end

        // Occupancy transitions; flush overrides every other event
        always_comb begin
            state_n     = state;
            load_out    = 1'b0;
            load_skid   = 1'b0;
            skid_to_out = 1'b0;
            if (flush) begin
                state_n = ST_EMPTY;
            end else begin
                case (state)
                    ST_EMPTY: if (in_acc) begin
                        state_n  = ST_ONE;
                        load_out = 1'b1;
                    end
                    ST_ONE: begin
                        if (in_acc && out_acc) begin
                            load_out = 1'b1;
                        end else if (in_acc) begin
                            state_n   = ST_TWO;
                            load_skid = 1'b1;
                        end else if (out_acc) begin
                            state_n = ST_EMPTY;
                        end
                    end
                    ST_TWO: if (out_acc) begin
                        state_n     = ST_ONE;
                        skid_to_out = 1'b1;
                    end
                    default: state_n = ST_EMPTY;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_q  <= '0;
                skid_q <= '0;
            end else begin
                if (load_out)         out_q <= cur;
                else if (skid_to_out) out_q <= skid_q;
                if (flush)            skid_q <= '0;
                else if (load_skid)   skid_q <= cur;
            end
        end

        assign bus.in_ready  = (state != ST_TWO);
        assign bus.out_valid = (state != ST_EMPTY);
        assign bus.imm       = out_q.imm;
        assign bus.pc_rel    = out_q.pc_rel;
        assign bus.imm_err   = out_q.err;
    end else begin : g_comb
        logic unused_ctl;

        assign bus.in_ready  = bus.out_ready;
        assign bus.out_valid = bus.in_valid;
        assign bus.imm       = cur.imm;
        assign bus.pc_rel    = cur.pc_rel;
        assign bus.imm_err   = cur.err;
        assign unused_ctl    = ^{clk, rst_n, flush};
    end
endmodule
